// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation classes,
// immediate kinds and the registered control-strobe bundle.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] CLS_R     = 3'b000;
  localparam logic [2:0] CLS_I     = 3'b001;
  localparam logic [2:0] CLS_ADD   = 3'b010;
  localparam logic [2:0] CLS_BR    = 3'b011;
  localparam logic [2:0] CLS_PASSB = 3'b100;
  localparam logic [2:0] CLS_INV   = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_kind_e;

  typedef struct packed {
    logic [6:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       auipc;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Decoder bus: instruction word in, registered control strobes and
// immediate out. The fetch side is the master, the decoder the slave.
interface control_unit_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] Instruction;
  logic [6:0]      ALUOp;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrc;
  logic            MemRead;
  logic            MemWrite;
  logic            MemToReg;
  logic            Branch;
  logic            Jump;
  logic [XLEN-1:0] imm;
  logic            auipc;

  modport master (
    output Instruction,
    input  ALUOp, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
    input  MemToReg, Branch, Jump, imm, auipc
  );

  modport slave (
    input  Instruction,
    output ALUOp, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
    output MemToReg, Branch, Jump, imm, auipc
  );

endinterface

// File: rtl/control_unit_imm_gen.sv
// Combinational RV32I immediate generator; every form is sign-extended
// from instruction bit 31, and IMM_NONE yields zero.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:7] i_instr,
  input  imm_kind_e       i_kind,
  output logic [XLEN-1:0] o_imm
);

  // Select and assemble the immediate for the requested instruction format
  always_comb begin
    o_imm = '0;
    case (i_kind)
      IMM_I:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      IMM_S:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      IMM_J:   o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder: registers control strobes, ALU operation code and
// the sign-extended immediate one cycle after the instruction is sampled.
module control_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  cu_bus
);
  import riscv_pkg::*;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic            w_b30;
  imm_kind_e       w_kind;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;

  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_imm;

  assign w_opcode = cu_bus.Instruction[6:0];
  assign w_f3     = cu_bus.Instruction[14:12];
  assign w_b30    = cu_bus.Instruction[30];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (cu_bus.Instruction[XLEN-1:7]),
    .i_kind  (w_kind),
    .o_imm   (w_imm)
  );

  // Opcode decode; unknown opcodes fall through to an all-zero NOP with the invalid marker
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = {CLS_INV, 1'b0, 3'b000};
    w_kind        = IMM_NONE;
    case (w_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = {CLS_R, w_b30, w_f3};
      end
      OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        // Only the shift-right pair uses bit 30 to pick arithmetic vs logical
        w_ctrl.alu_op    = {CLS_I, (w_f3 == 3'b101) ? w_b30 : 1'b0, w_f3};
        w_kind           = IMM_I;
      end
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_op     = {CLS_ADD, 1'b0, 3'b000};
        w_kind            = IMM_I;
      end
      OP_STORE: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_op    = {CLS_ADD, 1'b0, 3'b000};
        w_kind           = IMM_S;
      end
      OP_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = {CLS_BR, 1'b0, w_f3};
        w_kind        = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = {CLS_ADD, 1'b0, 3'b000};
        w_kind           = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = {CLS_ADD, 1'b0, 3'b000};
        w_kind           = IMM_I;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = {CLS_PASSB, 1'b0, 3'b000};
        w_kind           = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.auipc     = 1'b1;
        w_ctrl.alu_op    = {CLS_ADD, 1'b0, 3'b000};
        w_kind           = IMM_U;
      end
      default: begin
        w_ctrl        = '0;
        w_ctrl.alu_op = {CLS_INV, 1'b0, 3'b000};
        w_kind        = IMM_NONE;
      end
    endcase
  end

  // Output register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_imm  <= '0;
    end else begin
      r_ctrl <= w_ctrl;
      r_imm  <= w_imm;
    end
  end

  assign cu_bus.ALUOp    = r_ctrl.alu_op;
  assign cu_bus.RegDst   = r_ctrl.reg_dst;
  assign cu_bus.RegWrite = r_ctrl.reg_write;
  assign cu_bus.ALUSrc   = r_ctrl.alu_src;
  assign cu_bus.MemRead  = r_ctrl.mem_read;
  assign cu_bus.MemWrite = r_ctrl.mem_write;
  assign cu_bus.MemToReg = r_ctrl.mem_to_reg;
  assign cu_bus.Branch   = r_ctrl.branch;
  assign cu_bus.Jump     = r_ctrl.jump;
  assign cu_bus.auipc    = r_ctrl.auipc;
  assign cu_bus.imm      = r_imm;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-decoded RV32I words checked
// against the registered strobes, ALUOp and immediate.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  control_unit_if cu_if ();

  control_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cu_bus (cu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemToReg,Branch,Jump,auipc}
  function automatic logic [8:0] strobes();
    return {cu_if.RegDst, cu_if.RegWrite, cu_if.ALUSrc, cu_if.MemRead,
            cu_if.MemWrite, cu_if.MemToReg, cu_if.Branch, cu_if.Jump, cu_if.auipc};
  endfunction

  task automatic drive(input logic [31:0] ins);
    @(negedge clk);
    cu_if.Instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cu_if.Instruction = 32'h002081B3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobes() !== 9'h000 || cu_if.ALUOp !== 7'h00 || cu_if.imm !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: str=%b op=%h imm=%h want 0/00/0", strobes(), cu_if.ALUOp, cu_if.imm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (strobes() !== 9'h000 || cu_if.ALUOp !== 7'h00) begin
      failures++;
      $display("FAIL reset_release_early: str=%b op=%h want 0/00", strobes(), cu_if.ALUOp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (strobes() !== 9'b010000000 || cu_if.ALUOp !== 7'h00) begin
      failures++;
      $display("FAIL reset_release_edge: str=%b op=%h want 010000000/00", strobes(), cu_if.ALUOp);
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins  [4] = '{32'h002081B3, 32'h402081B3, 32'h4030D093, 32'h40008093};
    logic [6:0]  op   [4] = '{7'h00, 7'h08, 7'h1D, 7'h10};
    logic [8:0]  str  [4] = '{9'b010000000, 9'b010000000, 9'b011000000, 9'b011000000};
    logic [31:0] im   [4] = '{32'h0, 32'h0, 32'h00000403, 32'h00000400};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i]);
      checks++;
      if (strobes() !== str[i] || cu_if.ALUOp !== op[i] || cu_if.imm !== im[i]) begin
        failures++;
        $display("FAIL alu[%0d] %h: str=%b op=%h imm=%h want %b/%h/%h", i, ins[i],
                 strobes(), cu_if.ALUOp, cu_if.imm, str[i], op[i], im[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [31:0] ins  [2] = '{32'hFFC12283, 32'h00512423};
    logic [8:0]  str  [2] = '{9'b011101000, 9'b001010000};
    logic [31:0] im   [2] = '{32'hFFFFFFFC, 32'h00000008};
    for (int i = 0; i < 2; i++) begin
      drive(ins[i]);
      checks++;
      if (strobes() !== str[i] || cu_if.ALUOp !== 7'h20 || cu_if.imm !== im[i]) begin
        failures++;
        $display("FAIL mem[%0d] %h: str=%b op=%h imm=%h want %b/20/%h", i, ins[i],
                 strobes(), cu_if.ALUOp, cu_if.imm, str[i], im[i]);
      end
    end
  endtask

  task automatic test_flow();
    logic [31:0] ins  [3] = '{32'hFE208CE3, 32'hFF9FF0EF, 32'h00C08067};
    logic [6:0]  op   [3] = '{7'h30, 7'h20, 7'h20};
    logic [8:0]  str  [3] = '{9'b000000100, 9'b111000010, 9'b111000010};
    logic [31:0] im   [3] = '{32'hFFFFFFF8, 32'hFFFFFFF8, 32'h0000000C};
    for (int i = 0; i < 3; i++) begin
      drive(ins[i]);
      checks++;
      if (strobes() !== str[i] || cu_if.ALUOp !== op[i] || cu_if.imm !== im[i]) begin
        failures++;
        $display("FAIL flow[%0d] %h: str=%b op=%h imm=%h want %b/%h/%h", i, ins[i],
                 strobes(), cu_if.ALUOp, cu_if.imm, str[i], op[i], im[i]);
      end
    end
  endtask

  task automatic test_upper_invalid();
    logic [31:0] ins  [4] = '{32'h123450B7, 32'h00001097, 32'h00000000, 32'h0000007F};
    logic [6:0]  op   [4] = '{7'h40, 7'h20, 7'h70, 7'h70};
    logic [8:0]  str  [4] = '{9'b011000000, 9'b011000001, 9'b000000000, 9'b000000000};
    logic [31:0] im   [4] = '{32'h12345000, 32'h00001000, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i]);
      checks++;
      if (strobes() !== str[i] || cu_if.ALUOp !== op[i] || cu_if.imm !== im[i]) begin
        failures++;
        $display("FAIL upper_inv[%0d] %h: str=%b op=%h imm=%h want %b/%h/%h", i, ins[i],
                 strobes(), cu_if.ALUOp, cu_if.imm, str[i], op[i], im[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cu_if.Instruction = 32'hFFC12283;
    @(posedge clk);
    #1;
    cu_if.Instruction = 32'h00512423;
    #1;
    checks++;
    if (strobes() !== 9'b011101000 || cu_if.imm !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL b2b_hold: str=%b imm=%h want 011101000/fffffffc", strobes(), cu_if.imm);
    end
    @(posedge clk);
    #1;
    checks++;
    if (strobes() !== 9'b001010000 || cu_if.imm !== 32'h00000008) begin
      failures++;
      $display("FAIL b2b_next: str=%b imm=%h want 001010000/00000008", strobes(), cu_if.imm);
    end
  endtask

  task automatic test_async_reset();
    drive(32'hFF9FF0EF);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (strobes() !== 9'h000 || cu_if.ALUOp !== 7'h00 || cu_if.imm !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: str=%b op=%h imm=%h want 0/00/0", strobes(), cu_if.ALUOp, cu_if.imm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h123450B7);
    checks++;
    if (cu_if.ALUOp !== 7'h40 || cu_if.imm !== 32'h12345000) begin
      failures++;
      $display("FAIL after_reset: op=%h imm=%h want 40/12345000", cu_if.ALUOp, cu_if.imm);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    cu_if.Instruction = 32'h0;
    test_reset();
    test_alu();
    test_mem();
    test_flow();
    test_upper_invalid();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
